muldiv_unit: RTL and testbench

//  Multi-cycle unsigned multiply/divide/modulo responder for the datapath's

---
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply / divide / modulo unit. One iteration per clock,
// WIDTH iterations per op; shift-add multiply and restoring divide share one accumulator.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] OP_MUL = 6'b001001;
  localparam logic [5:0] OP_DIV = 6'b001010;
  localparam logic [5:0] OP_MOD = 6'b001011;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [5:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_quo;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_start_ok;
  logic [CW-1:0]    w_bit_idx;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_start_ok = start && ((operation == OP_MUL) || (operation == OP_DIV) ||
                                (operation == OP_MOD));

  // Multiply walks the multiplier LSB-first; divide walks the dividend MSB-first.
  always_comb begin
    w_bit_idx  = CNT_LAST - r_cnt;
    w_mul_acc  = r_acc + (r_b[r_cnt] ? (r_a << r_cnt) : '0);
    w_rem_sh   = {r_acc, r_a[w_bit_idx]};
    w_rem_diff = w_rem_sh - {1'b0, r_b};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    w_rem_nxt  = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    w_acc_nxt  = (r_op == OP_MUL) ? w_mul_acc : w_rem_nxt;
    case (r_op)
      OP_MUL:  w_res_nxt = w_mul_acc;
      OP_DIV:  w_res_nxt = w_quo_nxt;
      default: w_res_nxt = w_rem_nxt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_res_nxt;
            r_zero   <= (w_res_nxt == '0);
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          // DONE accepts a new start so ops can run back-to-back.
          if (w_start_ok) begin
            r_op    <= operation;
            r_a     <= data1;
            r_b     <= data2;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_quo   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops,
// checked against plain-arithmetic expectations including done-cycle latency.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] OP_MUL = 6'b001001;
  localparam logic [5:0] OP_DIV = 6'b001010;
  localparam logic [5:0] OP_MOD = 6'b001011;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   operation;
  logic [W-1:0] data1, data2;
  logic         busy, done, zero;
  logic [W-1:0] result;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .operation(operation),
    .data1(data1), .data2(data2), .busy(busy), .done(done),
    .result(result), .zero(zero)
  );

  always #5 clock = ~clock;

  typedef struct { logic [W-1:0] res; int cyc; } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(logic [5:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 0) ? {W{1'b1}} : a / b;
      OP_MOD:  return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", W'(zero), W'(e.res == 0));
        chk("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Called at a negedge; start is seen by the following posedge.
  task automatic send(logic [5:0] op, logic [W-1:0] a, logic [W-1:0] b, bit accept);
    exp_t e;
    operation = op; data1 = a; data2 = b; start = 1'b1;
    if (accept) begin
      e.res = model(op, a, b);
      e.cyc = cyc + 1 + W;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    operation = 6'($urandom);
    data1 = $urandom;
    data2 = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      @(negedge clock);
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_done: got no done within 100 cycles expected a pulse");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (!busy && sb.size() == 0) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle", busy, sb.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]   op;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; operation = '0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", W'(zero), 1);
    reset = 1'b0;
    @(negedge clock);

    send(OP_MUL, 7, 6, 1);
    chk("busy_run", W'(busy), 1);
    wait_done();
    chk("busy_at_done", W'(busy), 0);
    wait_idle();

    send(OP_DIV, 100, 7, 1); wait_done();
    send(OP_MOD, 100, 7, 1); wait_done();
    send(OP_DIV, 5, 0, 1);   wait_done();
    send(OP_MOD, 5, 0, 1);   wait_done();
    send(OP_MUL, 32'hFFFF_FFFF, 2, 1); wait_done();
    send(OP_MUL, 0, 9, 1);   wait_done();
    wait_idle();

    // Start while busy is dropped.
    send(OP_MUL, 3, 3, 1);
    repeat (4) @(negedge clock);
    send(OP_DIV, 8, 2, 0);
    chk("busy_ignore", W'(busy), 1);
    wait_done();
    wait_idle();

    // Unknown opcode in IDLE stays idle.
    send(6'b000001, 1, 2, 0);
    chk("badop_busy", W'(busy), 0);
    repeat (2) @(negedge clock);
    chk("badop_busy2", W'(busy), 0);
    chk("badop_done", W'(done), 0);

    // Reset mid-op aborts with no done.
    send(OP_MUL, 123, 456, 1);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    chk("abort_busy", W'(busy), 0);
    chk("abort_done", W'(done), 0);
    chk("abort_result", result, 0);
    chk("abort_zero", W'(zero), 1);
    reset = 1'b0;
    @(negedge clock);
    send(OP_MUL, 11, 12, 1);
    wait_done();
    send(OP_DIV, 1000, 10, 1);
    wait_done();
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 15));
        1: a = W'($urandom_range(0, 255));
        2: if ($urandom_range(0, 2) == 0) b = '0;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(12, 63));
        send(op, a, b, 0);
      end else begin
        op = 6'(9 + $urandom_range(0, 2));
        send(op, a, b, 1);
        wait_done();
        if ($urandom_range(0, 1) == 0) begin
          wait_idle();
          repeat ($urandom_range(0, 3)) @(negedge clock);
        end
      end
    end

    wait_idle();
    chk("scoreboard_empty", W'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
